// File: rtl/div_pipe_fu.sv
// div_pipe_fu: pipelined RV32M DIV/DIVU/REM/REMU unit with valid/ready backpressure and flush
module div_pipe_fu #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_STAGE = 8,
  parameter int PHYS_REG_BITS  = 6,
  parameter int ROB_IDX_BITS   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_funct3,
  input  logic [XLEN-1:0]          in_rs1,
  input  logic [XLEN-1:0]          in_rs2,
  input  logic [PHYS_REG_BITS-1:0] in_pd,
  input  logic [ROB_IDX_BITS-1:0]  in_rob_idx,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_rd_data,
  output logic [PHYS_REG_BITS-1:0] out_pd,
  output logic [ROB_IDX_BITS-1:0]  out_rob_idx,
  output logic                     busy
);
  localparam int NS = XLEN / BITS_PER_STAGE;
  if (XLEN % BITS_PER_STAGE != 0) begin : g_bad_split
    $error("XLEN must be a multiple of BITS_PER_STAGE");
  end
  typedef struct packed {
    logic [2:0]               f3;
    logic [PHYS_REG_BITS-1:0] pd;
    logic [ROB_IDX_BITS-1:0]  rob;
    logic [XLEN-1:0]          rs1;
    logic                     qn;
    logic                     rn;
    logic                     dz;
    logic                     ov;
  } side_t;
  function automatic logic [2*XLEN:0] step(input logic [XLEN:0] r0, input logic [XLEN-1:0] q0, input logic [XLEN-1:0] d);
    logic [XLEN:0]   r;
    logic [XLEN-1:0] q;
    r = r0;
    q = q0;
    for (int i = 0; i < BITS_PER_STAGE; i++) begin
      r = {r[XLEN-1:0], q[XLEN-1]};
      q = {q[XLEN-2:0], 1'b0};
      if (r >= {1'b0, d}) begin
        r    = r - {1'b0, d};
        q[0] = 1'b1;
      end
    end
    return {r, q};
  endfunction
  logic [NS:0]     v;
  side_t           sb [0:NS];
  logic [XLEN:0]   pr [0:NS];
  logic [XLEN-1:0] qr [0:NS];
  logic [XLEN-1:0] dv [0:NS];
  logic [2*XLEN:0] nx [1:NS];
  logic            adv, sgn, s1, s2;
  logic [XLEN-1:0] abs_a, abs_b, q_out, r_out, res;
  assign adv   = ~out_valid | out_ready;
  assign in_ready = adv & ~flush;
  assign sgn   = ~in_funct3[0];
  assign s1    = sgn & in_rs1[XLEN-1];
  assign s2    = sgn & in_rs2[XLEN-1];
  assign abs_a = s1 ? -in_rs1 : in_rs1;
  assign abs_b = s2 ? -in_rs2 : in_rs2;
  for (genvar k = 1; k <= NS; k++) begin : g_stage
    assign nx[k] = step(pr[k-1], qr[k-1], dv[k-1]);
  end
  // Prep register plus NS division stages; the whole pipe shifts only when the output can move
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int k = 0; k <= NS; k++) begin
        sb[k] <= '0;
        pr[k] <= '0;
        qr[k] <= '0;
        dv[k] <= '0;
      end
    end else if (flush) begin
      v <= '0;
    end else if (adv) begin
      v     <= {v[NS-1:0], in_valid};
      sb[0] <= side_t'{f3: in_funct3, pd: in_pd, rob: in_rob_idx, rs1: in_rs1, qn: s1 ^ s2, rn: s1,
                       dz: in_rs2 == '0, ov: sgn & (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (in_rs2 == '1)};
      pr[0] <= '0;
      qr[0] <= abs_a;
      dv[0] <= abs_b;
      for (int k = 1; k <= NS; k++) begin
        sb[k] <= sb[k-1];
        pr[k] <= nx[k][2*XLEN:XLEN];
        qr[k] <= nx[k][XLEN-1:0];
        dv[k] <= dv[k-1];
      end
    end
  end
  assign q_out = sb[NS].qn ? -qr[NS] : qr[NS];
  assign r_out = sb[NS].rn ? -pr[NS][XLEN-1:0] : pr[NS][XLEN-1:0];
  assign res   = !sb[NS].f3[2] ? '0 :
                 sb[NS].dz ? (sb[NS].f3[1] ? sb[NS].rs1 : '1) :
                 sb[NS].ov ? (sb[NS].f3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}}) :
                 sb[NS].f3[1] ? r_out : q_out;
  assign out_valid   = v[NS] & ~flush;
  assign out_rd_data = out_valid ? res : '0;
  assign out_pd      = out_valid ? sb[NS].pd : '0;
  assign out_rob_idx = out_valid ? sb[NS].rob : '0;
  assign busy        = |v;
endmodule

// File: tb/tb_div_pipe_fu.sv
// tb_div_pipe_fu: directed vectors, stall/flush/reset sequences and random scoreboard run for div_pipe_fu
module tb_div_pipe_fu;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1, in_rs2, out_rd_data;
  logic [5:0]  in_pd, out_pd;
  logic [4:0]  in_rob_idx, out_rob_idx;
  always #5 clk = ~clk;
  div_pipe_fu dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pd(in_pd), .in_rob_idx(in_rob_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd_data(out_rd_data), .out_pd(out_pd),
    .out_rob_idx(out_rob_idx), .busy(busy)
  );
  typedef struct {
    logic [31:0] d;
    logic [5:0]  pd;
    logic [4:0]  rob;
  } exp_t;
  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;
  int   n_chk = 0, n_fail = 0, n_acc = 0, n_pop = 0;
  exp_t sbq[$];
  vec_t tv[16];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 32'd0;
    if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
    if (f[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
    case (f[1:0])
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction
  function automatic logic [31:0] rnd_op();
    case ($urandom % 6)
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom % 16);
      4:       return -32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction
  // Scoreboard: expected results queued on accept, compared while presented, popped on handshake
  always @(negedge clk) begin
    if (rst) sbq.delete();
    else if (flush) begin
      check("flush_out_valid", 64'(out_valid), 64'd0);
      sbq.delete();
    end else begin
      if (out_valid) begin
        if (sbq.size() == 0) check("unexpected_out", 64'(out_valid), 64'd0);
        else begin
          check("result", 64'({out_rd_data, out_pd, out_rob_idx}), 64'({sbq[0].d, sbq[0].pd, sbq[0].rob}));
          if (out_ready) begin
            void'(sbq.pop_front());
            n_pop++;
          end
        end
      end else check("idle_zero", 64'({out_rd_data, out_pd, out_rob_idx}), 64'd0);
      if (in_valid && in_ready) begin
        sbq.push_back('{ref_res(in_funct3, in_rs1, in_rs2), in_pd, in_rob_idx});
        n_acc++;
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input logic [5:0] pd, input logic [4:0] rob);
    int lat;
    in_valid = 1'b1;
    in_funct3 = f;
    in_rs1 = a;
    in_rs2 = b;
    in_pd = pd;
    in_rob_idx = rob;
    cyc();
    in_valid = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      cyc();
      lat++;
    end
    check({name, "_lat"}, 64'(lat), 64'd5);
    check({name, "_data"}, 64'({out_rd_data, out_pd, out_rob_idx}), 64'({e, pd, rob}));
    cyc();
  endtask
  initial begin
    int iss, p0, a0, c;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_funct3 = '0; in_rs1 = '0; in_rs2 = '0; in_pd = '0; in_rob_idx = '0;
    repeat (3) cyc();
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    tv[0]  = '{3'b100, 32'd100, 32'd7, 32'd14};
    tv[1]  = '{3'b110, 32'd100, 32'd7, 32'd2};
    tv[2]  = '{3'b100, -32'd7, 32'd2, 32'hFFFF_FFFD};
    tv[3]  = '{3'b110, -32'd7, 32'd2, 32'hFFFF_FFFF};
    tv[4]  = '{3'b101, 32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF};
    tv[5]  = '{3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF};
    tv[6]  = '{3'b110, 32'h1234, 32'd0, 32'h1234};
    tv[7]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    tv[8]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    tv[9]  = '{3'b111, 32'd100, 32'd7, 32'd2};
    tv[10] = '{3'b100, 32'd7, -32'd2, 32'hFFFF_FFFD};
    tv[11] = '{3'b110, 32'd7, -32'd2, 32'd1};
    tv[12] = '{3'b000, 32'd100, 32'd7, 32'd0};
    tv[13] = '{3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF};
    tv[14] = '{3'b111, 32'hFFFF_FFFF, 32'h10, 32'hF};
    tv[15] = '{3'b100, 32'd0, 32'd0, 32'hFFFF_FFFF};
    for (int i = 0; i < 16; i++) run_op($sformatf("vec%0d", i), tv[i].f, tv[i].a, tv[i].b, tv[i].e, 6'(i), 5'(i));
    iss = 0;
    p0 = n_pop;
    for (int k = 0; k < 40; k++) begin
      in_valid = iss < 8;
      in_funct3 = 3'(4 + iss % 4);
      in_rs1 = 32'(1000 + iss * 37);
      in_rs2 = 32'(iss + 3);
      in_pd = 6'(40 + iss);
      in_rob_idx = 5'(iss);
      out_ready = !(k >= 6 && k < 9);
      @(negedge clk);
      if (!out_ready && out_valid) check("stall_in_ready", 64'(in_ready), 64'd0);
      if (in_valid && in_ready) iss++;
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stall_count", 64'(n_pop - p0), 64'd8);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_funct3 = 3'b100; in_rs1 = 32'(50 + i); in_rs2 = 32'd3;
      in_pd = 6'(i); in_rob_idx = 5'(i);
      cyc();
    end
    in_valid = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("flush_no_out", 64'(out_valid), 64'd0);
      cyc();
    end
    run_op("post_flush", 3'b100, 32'd100, 32'd7, 32'd14, 6'd9, 5'd9);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_funct3 = 3'b111; in_rs1 = 32'(200 + i); in_rs2 = 32'd9;
      in_pd = 6'(i); in_rob_idx = 5'(i);
      cyc();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_no_out", 64'(out_valid), 64'd0);
      cyc();
    end
    a0 = n_acc;
    c = 0;
    while (n_acc - a0 < 10000 && c < 60000) begin
      in_valid = ($urandom % 4) != 0;
      in_funct3 = ($urandom % 8 == 0) ? 3'($urandom % 4) : 3'(4 + $urandom % 4);
      in_rs1 = rnd_op();
      in_rs2 = rnd_op();
      in_pd = 6'($urandom);
      in_rob_idx = 5'($urandom);
      out_ready = ($urandom % 4) != 0;
      flush = ($urandom % 250) == 0;
      cyc();
      c++;
    end
    check("random_ops", 64'(n_acc - a0 >= 10000), 64'd1);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    c = 0;
    while (sbq.size() != 0 && c < 30) begin
      cyc();
      c++;
    end
    check("drain", 64'(sbq.size()), 64'd0);
    check("drain_busy", 64'(busy), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
